// File: rtl/bcrypt_addr_pkg.sv
// Shared op codes and sequencer states for the bcrypt address register.
// Imported by addr_next_calc and addr_seq_reg.
package bcrypt_addr_pkg;

  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_LD_RESET  = 4'd1;
  localparam logic [3:0] OP_LD_VALUE  = 4'd2;
  localparam logic [3:0] OP_INC       = 4'd3;
  localparam logic [3:0] OP_INC_COND  = 4'd4;
  localparam logic [3:0] OP_DEC       = 4'd5;
  localparam logic [3:0] OP_B0RST     = 4'd6;
  localparam logic [3:0] OP_ADD2B1SET = 4'd7;
  localparam logic [3:0] OP_ADD2_COND = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/addr_next_calc.sv
// Combinational next-address and carry/borrow logic for addr_seq_reg.
// ADDR_SEQ_SATURATE_EN clamps increments at all-ones and OP_DEC at zero.
module addr_next_calc
  import bcrypt_addr_pkg::*;
#(
  parameter int unsigned          WIDTH      = 10,
  parameter logic [WIDTH-1:0]     RESET_ADDR = 1
) (
  input  logic [3:0]       op,
  input  logic             step,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] ld_value,
  input  logic             cond,
  output logic [WIDTH-1:0] next_addr,
  output logic             carry
);

  localparam logic [WIDTH:0]   ONE_X = 1;
  localparam logic [WIDTH-1:0] ONE_W = 1;

  // sum[WIDTH] is the carry/borrow out of the address MSB for every path
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hi;
  logic [1:0]       c;

  always_comb begin
    sum = {1'b0, addr};
    hi  = '0;
    c   = '0;
    if (step) begin
      sum = {1'b0, addr} + ONE_X;
    end else begin
      case (op)
        OP_LD_RESET: sum = {1'b0, RESET_ADDR};
        OP_LD_VALUE: sum = {1'b0, ld_value};
        OP_INC:      sum = {1'b0, addr} + ONE_X;
        OP_INC_COND: sum = {1'b0, addr} + {{WIDTH{1'b0}}, cond};
        OP_DEC:      sum = {1'b0, addr} - ONE_X;
        OP_B0RST:    sum = {1'b0, addr[WIDTH-1:1], 1'b0};
        OP_ADD2B1SET: begin
          hi  = {1'b0, addr[WIDTH-1:1]} + ONE_W;
          sum = {hi, 1'b1};
        end
        OP_ADD2_COND: begin
          c   = {1'b0, addr[0]} + {1'b0, cond};
          hi  = {1'b0, addr[WIDTH-1:1]} + {{(WIDTH-1){1'b0}}, c[1]};
          sum = {hi, c[0]};
        end
        default: sum = {1'b0, addr};
      endcase
    end
  end

  assign carry = sum[WIDTH];

`ifdef ADDR_SEQ_SATURATE_EN
  assign next_addr = !carry ? sum[WIDTH-1:0] :
                     (!step && op == OP_DEC) ? '0 : '1;
`else
  assign next_addr = sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/addr_seq_reg.sv
// Op-code address register with valid/ready burst sequencer and compare flags.
// Build with ADDR_SEQ_SATURATE_EN for saturating instead of modulo arithmetic.
module addr_seq_reg
  import bcrypt_addr_pkg::*;
#(
  parameter int unsigned      WIDTH      = 10,
  parameter logic [WIDTH-1:0] RESET_ADDR = 1,
  parameter logic [WIDTH-1:0] CMP_A      = 1022,
  parameter logic [WIDTH-1:0] CMP_B      = 1023
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             op_en,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] ld_value,
  input  logic             cond,
  input  logic             burst_start,
  input  logic [WIDTH-1:0] burst_len,
  input  logic             addr_ready,
  output logic [WIDTH-1:0] addr,
  output logic             addr_valid,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             eq_a,
  output logic             eq_b
);

  localparam logic [WIDTH-1:0] ONE = 1;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] next_addr;
  logic             carry;

  addr_next_calc #(
    .WIDTH      (WIDTH),
    .RESET_ADDR (RESET_ADDR)
  ) u_calc (
    .op        (op),
    .step      (state == BURST),
    .addr      (addr),
    .ld_value  (ld_value),
    .cond      (cond),
    .next_addr (next_addr),
    .carry     (carry)
  );

  assign eq_a = (addr == CMP_A);
  assign eq_b = (addr == CMP_B);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= RESET_ADDR;
      cnt        <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          // burst_start wins over op_en; the current addr is the first beat
          if (burst_start) begin
            cnt <= burst_len;
            if (burst_len != '0) begin
              state      <= BURST;
              addr_valid <= 1'b1;
              busy       <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (op_en) begin
            addr <= next_addr;
            wrap <= carry;
          end
        end
        BURST: begin
          if (addr_ready) begin
            addr <= next_addr;
            wrap <= carry;
            cnt  <= cnt - ONE;
            if (cnt == ONE) begin
              state      <= DONE;
              addr_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          if (op_en) begin
            addr <= next_addr;
            wrap <= carry;
          end
        end
        default: begin
          state      <= IDLE;
          addr_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_seq_reg.sv
// Directed self-checking bench for addr_seq_reg (WIDTH=10, default parameters).
// Expectations follow ADDR_SEQ_SATURATE_EN when the bench is built with it.
module tb_addr_seq_reg;
  import bcrypt_addr_pkg::*;

  localparam int unsigned W = 10;
`ifdef ADDR_SEQ_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         rst, op_en, cond, burst_start, addr_ready;
  logic [3:0]   op;
  logic [W-1:0] ld_value, burst_len;
  logic [W-1:0] addr;
  logic         addr_valid, busy, done, wrap, eq_a, eq_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 CLK = ~CLK;

  addr_seq_reg #(
    .WIDTH      (W),
    .RESET_ADDR (10'd1),
    .CMP_A      (10'd1022),
    .CMP_B      (10'd1023)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .op_en       (op_en),
    .op          (op),
    .ld_value    (ld_value),
    .cond        (cond),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .addr_ready  (addr_ready),
    .addr        (addr),
    .addr_valid  (addr_valid),
    .busy        (busy),
    .done        (done),
    .wrap        (wrap),
    .eq_a        (eq_a),
    .eq_b        (eq_b)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_op(input logic [3:0] o, input int unsigned v, input logic c);
    op_en    = 1'b1;
    op       = o;
    ld_value = W'(v);
    cond     = c;
    tick();
    op_en = 1'b0;
    op    = OP_NOP;
    cond  = 1'b0;
  endtask

  int unsigned exp_burst[6];
  int unsigned k, t, wraps;

  initial begin
    rst = 1'b1; op_en = 1'b0; op = OP_NOP; ld_value = '0; cond = 1'b0;
    burst_start = 1'b0; burst_len = '0; addr_ready = 1'b0;
    if (SAT) exp_burst = '{1020, 1021, 1022, 1023, 1023, 1023};
    else     exp_burst = '{1020, 1021, 1022, 1023, 0, 1};

    tick(); tick();
    rst = 1'b0;
    check_eq("rst_addr", 32'(addr), 1);
    check_eq("rst_valid", 32'(addr_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_wrap", 32'(wrap), 0);
    check_eq("rst_eq_a", 32'(eq_a), 0);
    check_eq("rst_eq_b", 32'(eq_b), 0);

    // ADD2 pairing and compare flags
    do_op(OP_LD_VALUE, 1021, 1'b0);
    check_eq("ld_1021", 32'(addr), 1021);
    check_eq("ld_1021_eq_a", 32'(eq_a), 0);
    do_op(OP_ADD2_COND, 0, 1'b1);
    check_eq("add2c_1022", 32'(addr), 1022);
    check_eq("add2c_eq_a", 32'(eq_a), 1);
    check_eq("add2c_eq_b0", 32'(eq_b), 0);
    do_op(OP_ADD2_COND, 0, 1'b1);
    check_eq("add2c_1023", 32'(addr), 1023);
    check_eq("add2c_eq_b", 32'(eq_b), 1);
    check_eq("add2c_eq_a0", 32'(eq_a), 0);
    do_op(OP_ADD2B1SET, 0, 1'b0);
    check_eq("add2b1_wrap_addr", 32'(addr), SAT ? 1023 : 1);
    check_eq("add2b1_wrap", 32'(wrap), 1);

    // Small-op walk
    do_op(OP_LD_VALUE, 5, 1'b0);
    check_eq("ld_5_wrap_clear", 32'(wrap), 0);
    do_op(OP_INC_COND, 0, 1'b0); check_eq("inc_cond0", 32'(addr), 5);
    do_op(OP_INC_COND, 0, 1'b1); check_eq("inc_cond1", 32'(addr), 6);
    do_op(OP_B0RST, 0, 1'b0);    check_eq("b0rst_even", 32'(addr), 6);
    do_op(OP_INC, 0, 1'b0);      check_eq("inc", 32'(addr), 7);
    do_op(OP_B0RST, 0, 1'b0);    check_eq("b0rst_odd", 32'(addr), 6);
    do_op(OP_DEC, 0, 1'b0);      check_eq("dec", 32'(addr), 5);
    check_eq("dec_no_wrap", 32'(wrap), 0);
    do_op(4'd15, 0, 1'b0);       check_eq("undef_op", 32'(addr), 5);
    do_op(OP_LD_RESET, 0, 1'b0); check_eq("ld_reset", 32'(addr), 1);

    // Top and bottom boundaries
    do_op(OP_LD_VALUE, 1023, 1'b0);
    do_op(OP_INC, 0, 1'b0);
    check_eq("inc_top_addr", 32'(addr), SAT ? 1023 : 0);
    check_eq("inc_top_wrap", 32'(wrap), 1);
    tick();
    check_eq("wrap_one_cycle", 32'(wrap), 0);
    do_op(OP_LD_VALUE, 0, 1'b0);
    do_op(OP_DEC, 0, 1'b0);
    check_eq("dec_zero_addr", 32'(addr), SAT ? 0 : 1023);
    check_eq("dec_zero_wrap", 32'(wrap), 1);

    // Burst of 6 from 1020 with alternating ready
    do_op(OP_LD_VALUE, 1020, 1'b0);
    burst_start = 1'b1; burst_len = 10'd6;
    tick();
    burst_start = 1'b0;
    check_eq("burst_busy", 32'(busy), 1);
    k = 0; t = 0; wraps = 0;
    while (k < 6 && t < 40) begin
      addr_ready = (t % 2 == 0);
      check_eq("burst_addr", 32'(addr), exp_burst[k]);
      check_eq("burst_valid", 32'(addr_valid), 1);
      check_eq("burst_no_done", 32'(done), 0);
      if (addr_ready) k++;
      tick();
      wraps += 32'(wrap);
      t++;
    end
    addr_ready = 1'b0;
    check_eq("burst_done", 32'(done), 1);
    check_eq("burst_final_addr", 32'(addr), SAT ? 1023 : 2);
    check_eq("burst_end_valid", 32'(addr_valid), 0);
    check_eq("burst_end_busy", 32'(busy), 0);
    check_eq("burst_wraps", wraps, SAT ? 3 : 1);
    tick();
    check_eq("burst_done_pulse", 32'(done), 0);

    // Zero-length burst together with op_en: op is dropped
    burst_start = 1'b1; burst_len = '0; op_en = 1'b1; op = OP_INC;
    tick();
    burst_start = 1'b0; op_en = 1'b0; op = OP_NOP;
    check_eq("zlen_addr", 32'(addr), SAT ? 1023 : 2);
    check_eq("zlen_done", 32'(done), 1);
    check_eq("zlen_valid", 32'(addr_valid), 0);
    // In DONE: op honoured, burst_start ignored
    burst_start = 1'b1; burst_len = 10'd5;
    do_op(OP_LD_VALUE, 50, 1'b0);
    burst_start = 1'b0;
    check_eq("done_op_addr", 32'(addr), 50);
    check_eq("done_op_done", 32'(done), 0);
    check_eq("done_op_valid", 32'(addr_valid), 0);
    tick();
    check_eq("done_start_ignored", 32'(addr_valid), 0);

    // Reset in the middle of a 10-beat burst
    do_op(OP_LD_VALUE, 100, 1'b0);
    burst_start = 1'b1; burst_len = 10'd10; addr_ready = 1'b1;
    tick();
    burst_start = 1'b0;
    check_eq("mid_beat1", 32'(addr), 100);
    tick();
    tick();
    check_eq("mid_beat3", 32'(addr), 102);
    rst = 1'b1;
    tick();
    rst = 1'b0; addr_ready = 1'b0;
    check_eq("mid_rst_addr", 32'(addr), 1);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_valid", 32'(addr_valid), 0);
    check_eq("mid_rst_done", 32'(done), 0);
    tick();
    check_eq("mid_rst_no_done", 32'(done), 0);
    burst_start = 1'b1; burst_len = 10'd2; addr_ready = 1'b1;
    tick();
    burst_start = 1'b0;
    check_eq("post_rst_beat1", 32'(addr), 1);
    check_eq("post_rst_valid", 32'(addr_valid), 1);
    tick();
    check_eq("post_rst_beat2", 32'(addr), 2);
    tick();
    addr_ready = 1'b0;
    check_eq("post_rst_done", 32'(done), 1);
    check_eq("post_rst_addr", 32'(addr), 3);
    check_eq("post_rst_valid_end", 32'(addr_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_seq_reg.md
Name: addr_seq_reg

Overview:
- Parametrised address register with an op-code port for the bcrypt core. Covers the fixed-width S/P/PD address registers in one reusable block.
- Adds a hardware burst sequencer with a valid/ready handshake, carry/wrap detection and two parametrised compare flags.
- Sits between the bcrypt core control FSM and one memory write/read port. One instance is used per address stream.

Parameters:
- WIDTH, 10, address width in bits (2..16).
- RESET_ADDR, 1, value loaded at reset and by OP_LD_RESET.
- CMP_A, 1022, compare value driving eq_a.
- CMP_B, 1023, compare value driving eq_b.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- op_en  in  1  execute op this cycle.
- op  in  4  op code; encodings come from the package.
- ld_value  in  WIDTH  operand for OP_LD_VALUE.
- cond  in  1  conditional increment bit.
- burst_start  in  1  start an auto-increment burst from the current addr.
- burst_len  in  WIDTH  number of addresses in the burst.
- addr_ready  in  1  consumer accepts the current addr.
- addr  out  WIDTH  current address.
- addr_valid  out  1  high during a burst.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- wrap  out  1  one-cycle pulse when an increment carried out of the MSB.
- eq_a  out  1  combinational flag, addr == CMP_A.
- eq_b  out  1  combinational flag, addr == CMP_B.

Behaviour:
- Reset: addr=RESET_ADDR, state=IDLE, addr_valid=0, busy=0, done=0, wrap=0.
- rst mid-burst aborts the burst with no done pulse.
- Ops (applied in IDLE when op_en=1; effect visible the next cycle):
  - OP_NOP: no change.
  - OP_LD_RESET: addr<=RESET_ADDR.
  - OP_LD_VALUE: addr<=ld_value.
  - OP_INC: addr<=addr+1.
  - OP_INC_COND: addr<=addr+cond.
  - OP_DEC: addr<=addr-1, wraps 0 -> all-ones, wrap pulses.
  - OP_B0RST: clear bit0.
  - OP_ADD2B1SET: {addr[W-1:1]+1, 1}.
  - OP_ADD2_COND: c=addr[0]+cond (2 bits); addr<={addr[W-1:1]+c[1], c[0]}.
  - Undefined codes behave as OP_NOP.
- Arithmetic is modulo 2^WIDTH. wrap pulses on the cycle after any op or burst step whose result carried or borrowed out.
- FSM states: IDLE, BURST, DONE.
  - IDLE -> BURST on burst_start with burst_len!=0; latch cnt=burst_len.
  - IDLE -> DONE on burst_start with burst_len==0.
  - burst_start has priority over op_en in the same cycle; the op is dropped.
  - BURST: addr_valid=busy=1. On addr_ready: addr<=addr+1, cnt<=cnt-1. When cnt==1 and addr_ready, go to DONE.
  - addr holds while addr_ready=0.
  - op_en and burst_start are ignored in BURST.
  - DONE: done=1 for one cycle, addr_valid=0, busy=0, then IDLE.
  - op_en is honoured in DONE; burst_start is ignored in DONE.
- Latency: op result one cycle after op_en. The first burst address is the addr held at burst_start, presented the cycle after start.
- Burst wrap: addr passes all-ones -> 0 and wrap pulses; the burst continues.

Optional Feature:
- Macro ADDR_SEQ_SATURATE_EN.
- Defined: increments (OP_INC, OP_INC_COND, ADD2 ops, burst steps) saturate at all-ones and OP_DEC saturates at 0. wrap pulses when a saturation occurs. A burst that saturates still counts down cnt and reaches DONE normally.
- Undefined: modulo wrap as described above.

Decomposition:
- Package bcrypt_addr_pkg holds:
  - the op code localparams (OP_NOP=0, OP_LD_RESET=1, OP_LD_VALUE=2, OP_INC=3, OP_INC_COND=4, OP_DEC=5, OP_B0RST=6, OP_ADD2B1SET=7, OP_ADD2_COND=8);
  - the FSM state encodings (IDLE=0, BURST=1, DONE=2).
- Sub-module addr_next_calc: combinational next-address and carry/saturate logic, parametrised on WIDTH. The top holds the register, the counter and the FSM.

Test Plan:
- Reset: rst=1 for 2 cycles -> addr=1; addr_valid, busy, done, wrap all 0; eq_a=eq_b=0.
- ADD2 pairing: OP_LD_VALUE 1021, then OP_ADD2_COND with cond=1 -> addr=1022, eq_a=1. Repeat OP_ADD2_COND with cond=1 -> addr=1023, eq_b=1.
- Burst with stalls: addr=1020, burst_start with burst_len=6, addr_ready toggling 1,0,1,...
  - Accepted addresses 1020, 1021, 1022, 1023, 0, 1.
  - wrap pulses once at the 1023 -> 0 step.
  - done pulses one cycle after the 6th accept; final addr=2.
- Priority and zero length: burst_start with burst_len=0 together with op_en OP_INC -> addr unchanged, done pulses next cycle, addr_valid never 1.
- Reset mid-burst: rst at the 3rd beat of a 10-long burst -> addr=1, busy=0, no done pulse. A new burst then runs normally.
- Macro build with ADDR_SEQ_SATURATE_EN: addr=1023, OP_INC -> addr stays 1023, wrap pulses. addr=0, OP_DEC -> addr stays 0, wrap pulses.
